// File: rtl/qsys_led_sequencer.sv
// RGB LED pattern generator driving an Avalon-ST LED sink: ramp, breathe, static and off modes.
// Optional build macro LEDSEQ_GAMMA_EN squares ramp levels ((v*v)>>CH_W) ahead of the output register.
//
// state   | meaning
// ST_UP   | level increments on each tick until it reaches MAX
// ST_DOWN | level decrements on each tick until it reaches 0
module qsys_led_sequencer #(
  parameter int CH_W    = 8,
  parameter int PRESC_W = 19
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset_n,
  input  logic [1:0]          coe_MODE_sel,
  input  logic                coe_RUN_en,
  input  logic [3*CH_W-1:0]   coe_STATIC_rgb,
  output logic [3*CH_W-1:0]   aso_LEDS_data,
  output logic                aso_LEDS_valid,
  input  logic                aso_LEDS_ready
);

  typedef enum logic {ST_UP, ST_DOWN} state_t;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_t;

  localparam logic [CH_W-1:0] LVL_MAX  = '1;
  localparam logic [CH_W-1:0] LVL_ZERO = '0;

  state_t              state_q, state_d;
  ch_t                 ch_q, ch_d;
  logic [CH_W-1:0]     level_q, level_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [1:0]          mode_q, mode_d;
  logic [3*CH_W-1:0]   data_d;
  logic                valid_d;
  logic                stall;
  logic                adv;
  logic [3*CH_W-1:0]   hold_val;

  function automatic logic [CH_W-1:0] shape(input logic [CH_W-1:0] v);
`ifdef LEDSEQ_GAMMA_EN
    logic [2*CH_W-1:0] sq;
    sq = v * v;
    return sq[2*CH_W-1:CH_W];
`else
    return v;
`endif
  endfunction

  function automatic logic [3*CH_W-1:0] ramp_val(input logic [CH_W-1:0] lvl, input ch_t ch,
                                                 input logic breathe);
    logic [CH_W-1:0] g;
    g = shape(lvl);
    if (breathe) return {g, g, g};
    case (ch)
      CH_R:    return {g, LVL_ZERO, LVL_ZERO};
      CH_G:    return {LVL_ZERO, g, LVL_ZERO};
      default: return {LVL_ZERO, LVL_ZERO, g};
    endcase
  endfunction

  assign stall    = aso_LEDS_valid & ~aso_LEDS_ready;
  assign adv      = coe_RUN_en & ~stall;
  assign hold_val = (mode_q == 2'd2) ? coe_STATIC_rgb : '0;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    level_d = level_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    data_d  = aso_LEDS_data;
    valid_d = aso_LEDS_valid & ~aso_LEDS_ready;

    if (coe_MODE_sel != mode_q) begin
      // mode switch restarts the pattern and overrides any pending beat, even under stall
      mode_d  = coe_MODE_sel;
      state_d = ST_UP;
      ch_d    = CH_R;
      level_d = '0;
      presc_d = '0;
      data_d  = (coe_MODE_sel == 2'd2) ? coe_STATIC_rgb : '0;
      valid_d = 1'b1;
    end else if (adv) begin
      presc_d = presc_q + 1'b1;
      if (&presc_q) begin
        if (!mode_q[1]) begin
          case (state_q)
            ST_UP: begin
              level_d = level_q + 1'b1;
              if (level_d == LVL_MAX) state_d = ST_DOWN;
            end
            default: begin
              level_d = level_q - 1'b1;
              if (level_d == LVL_ZERO) begin
                state_d = ST_UP;
                if (mode_q == 2'd0) begin
                  case (ch_q)
                    CH_R:    ch_d = CH_G;
                    CH_G:    ch_d = CH_B;
                    default: ch_d = CH_R;
                  endcase
                end
              end
            end
          endcase
          data_d  = ramp_val(level_d, ch_q, mode_q[0]);
          valid_d = 1'b1;
        end else if (hold_val != aso_LEDS_data) begin
          data_d  = hold_val;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q        <= ST_UP;
      ch_q           <= CH_R;
      level_q        <= '0;
      presc_q        <= '0;
      mode_q         <= 2'd0;
      aso_LEDS_data  <= '0;
      aso_LEDS_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      level_q        <= level_d;
      presc_q        <= presc_d;
      mode_q         <= mode_d;
      aso_LEDS_data  <= data_d;
      aso_LEDS_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_qsys_led_sequencer.sv
// Directed bench for qsys_led_sequencer with CH_W=2, PRESC_W=2 (tick every 4 enabled cycles).
module tb_qsys_led_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode_sel;
  logic       run_en;
  logic [5:0] static_rgb;
  logic [5:0] leds_data;
  logic       leds_valid;
  logic       leds_ready;

  int checks   = 0;
  int failures = 0;

  qsys_led_sequencer #(.CH_W(2), .PRESC_W(2)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .coe_MODE_sel     (mode_sel),
    .coe_RUN_en       (run_en),
    .coe_STATIC_rgb   (static_rgb),
    .aso_LEDS_data    (leds_data),
    .aso_LEDS_valid   (leds_valid),
    .aso_LEDS_ready   (leds_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // waits on falling edges until valid is seen, bounded by limit cycles
  task automatic next_beat(input string tag, input int limit, output logic [5:0] d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!leds_valid && n < limit);
    if (!leds_valid) check_val({tag, "_timeout"}, {31'd0, leds_valid}, 32'd1);
    d = leds_data;
  endtask

  function automatic logic [5:0] ramp_exp(input int k);
    int seq [6] = '{1, 2, 3, 2, 1, 0};
    int lvl, ch;
    lvl = seq[k % 6];
    ch  = (k / 6) % 3;
    return 6'(lvl << (2 * (2 - ch)));
  endfunction

  logic [5:0] d;
  int         n;
  int         vcnt;
  int         bad;
  logic [5:0] breathe_exp [6] = '{6'd21, 6'd42, 6'd63, 6'd42, 6'd21, 6'd0};

  initial begin
    rst_n      = 1'b0;
    mode_sel   = 2'd0;
    run_en     = 1'b1;
    leds_ready = 1'b1;
    static_rgb = 6'b11_01_10;
    repeat (3) @(negedge clk);
    check_val("rst_data", {26'd0, leds_data}, 32'd0);
    check_val("rst_valid", {31'd0, leds_valid}, 32'd0);
    rst_n = 1'b1;

    // mode 0: R 1,2,3,2,1,0 then G, then B, then back to R
    for (int k = 0; k < 19; k++) begin
      next_beat("ramp", 20, d, n);
      check_val($sformatf("ramp_data%0d", k), {26'd0, d}, {26'd0, ramp_exp(k)});
      check_val($sformatf("ramp_gap%0d", k), n, 32'd4);
    end

    // mode 1: change beat of zeros, then breathe ramp
    mode_sel = 2'd1;
    next_beat("m1_chg", 20, d, n);
    check_val("m1_chg_data", {26'd0, d}, 32'd0);
    check_val("m1_chg_gap", n, 32'd1);
    for (int k = 0; k < 7; k++) begin
      next_beat("breathe", 20, d, n);
      check_val($sformatf("breathe_data%0d", k), {26'd0, d}, {26'd0, breathe_exp[k % 6]});
      check_val($sformatf("breathe_gap%0d", k), n, 32'd4);
    end

    // backpressure on the level-1 beat: held for 20 cycles, no level skipped
    leds_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!leds_valid || leds_data != 6'd21) bad++;
    end
    check_val("bp_hold_bad_cycles", bad, 32'd0);
    check_val("bp_hold_data", {26'd0, leds_data}, 32'd21);
    leds_ready = 1'b1;
    next_beat("bp_resume", 20, d, n);
    check_val("bp_resume_data", {26'd0, d}, 32'd42);
    check_val("bp_resume_gap", n, 32'd4);

    // pause two cycles into a tick: prescaler must resume where it froze
    @(negedge clk);
    check_val("run_accept_valid", {31'd0, leds_valid}, 32'd0);
    @(negedge clk);
    run_en = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (leds_valid) vcnt++;
    end
    check_val("run_pause_beats", vcnt, 32'd0);
    run_en = 1'b1;
    next_beat("run_resume", 20, d, n);
    check_val("run_resume_data", {26'd0, d}, 32'd63);
    check_val("run_resume_gap", n, 32'd2);

    // mode 0 restart, then switch to static mid-tick
    mode_sel = 2'd0;
    next_beat("m0_chg", 20, d, n);
    check_val("m0_chg_data", {26'd0, d}, 32'd0);
    next_beat("m0_r1", 20, d, n);
    check_val("m0_r1_data", {26'd0, d}, 32'd16);
    next_beat("m0_r2", 20, d, n);
    check_val("m0_r2_data", {26'd0, d}, 32'd32);
    @(negedge clk);
    mode_sel   = 2'd2;
    static_rgb = 6'b11_01_10;
    next_beat("m2_chg", 20, d, n);
    check_val("m2_chg_data", {26'd0, d}, 32'd54);
    check_val("m2_chg_gap", n, 32'd1);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (leds_valid) vcnt++;
    end
    check_val("m2_idle_beats", vcnt, 32'd0);
    static_rgb = 6'b00_00_11;
    next_beat("m2_newstatic", 8, d, n);
    check_val("m2_newstatic_data", {26'd0, d}, 32'd3);

    // back to ramp: zeros first, then R=1
    mode_sel = 2'd0;
    next_beat("m0_back", 20, d, n);
    check_val("m0_back_data", {26'd0, d}, 32'd0);
    check_val("m0_back_gap", n, 32'd1);
    next_beat("m0_back_r1", 20, d, n);
    check_val("m0_back_r1_data", {26'd0, d}, 32'd16);
    check_val("m0_back_r1_gap", n, 32'd4);

    // mode changes overwrite a stalled beat
    leds_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("stall_hold_data", {26'd0, leds_data}, 32'd16);
    mode_sel = 2'd2;
    @(negedge clk);
    check_val("stall_m2_data", {26'd0, leds_data}, 32'd3);
    check_val("stall_m2_valid", {31'd0, leds_valid}, 32'd1);
    mode_sel = 2'd3;
    @(negedge clk);
    check_val("stall_m3_data", {26'd0, leds_data}, 32'd0);
    check_val("stall_m3_valid", {31'd0, leds_valid}, 32'd1);
    leds_ready = 1'b1;
    @(negedge clk);
    check_val("m3_accept_valid", {31'd0, leds_valid}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (leds_valid) vcnt++;
    end
    check_val("m3_idle_beats", vcnt, 32'd0);

    // asynchronous reset in the middle of a beat
    mode_sel = 2'd1;
    next_beat("pre_rst_chg", 20, d, n);
    next_beat("pre_rst", 20, d, n);
    check_val("pre_rst_data", {26'd0, d}, 32'd21);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_data", {26'd0, leds_data}, 32'd0);
    check_val("async_rst_valid", {31'd0, leds_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
